// File: rtl/multicycle_cpu.sv
// multicycle_cpu: 8-bit multicycle core fetching 16-bit instructions over a request/ready bus.
// Optional macro CPU_BRANCH_EN enables BEQZ/JMP; without it opcodes B and C execute as NOP.
module multicycle_cpu #(
   parameter int ADDR_W = 8,
   parameter int NREGS  = 16
) (
   input  logic              clk,
   input  logic              rst,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [1:0]        mem_be,
   output logic [15:0]       mem_wdata,
   input  logic [15:0]       mem_rdata,
   input  logic              mem_ready,
   output logic [1:0]        flags,
   output logic              halted
);
   localparam int PCW = ADDR_W - 1;
   localparam int RW  = (NREGS > 1) ? $clog2(NREGS) : 1;

   localparam logic [1:0] S_FETCH = 2'd0;
   localparam logic [1:0] S_EXEC  = 2'd1;
   localparam logic [1:0] S_MEM   = 2'd2;
   localparam logic [1:0] S_HALT  = 2'd3;

   logic [1:0]        r_state;
   logic [PCW-1:0]    r_pc;
   logic [15:0]       r_inst;
   logic [7:0]        r_regs [NREGS];
   logic              r_carry;
   logic              r_zero;
   logic              r_halted;
   logic              r_mem_req;
   logic              r_mem_we;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [1:0]        r_mem_be;
   logic [15:0]       r_mem_wdata;

   logic [3:0]        w_op;
   logic [RW-1:0]     w_rd;
   logic [RW-1:0]     w_rs1;
   logic [RW-1:0]     w_rs2;
   logic [7:0]        w_imm;
   logic [7:0]        w_a;
   logic [7:0]        w_b;
   logic              w_alu_op;
   logic              w_is_mem;
   logic [8:0]        w_sum;
   logic [7:0]        w_alu;
   logic              w_alu_c;
   logic [PCW-1:0]    w_pc_inc;
   logic [PCW-1:0]    w_pc_next;
   logic [ADDR_W-1:0] w_daddr;
   logic              w_rf_we;
   logic [7:0]        w_rf_wdata;

   assign w_op  = r_inst[15:12];
   assign w_rd  = r_inst[8 +: RW];
   assign w_rs1 = r_inst[4 +: RW];
   assign w_rs2 = r_inst[0 +: RW];
   assign w_imm = r_inst[7:0];
   assign w_a   = r_regs[w_rs1];
   assign w_b   = r_regs[w_rs2];

   assign w_alu_op = (w_op >= 4'h1) && (w_op <= 4'h7);
   assign w_is_mem = (w_op == 4'h9) || (w_op == 4'hA);

   // The 9-bit difference's top bit is the unsigned borrow, so ADD and SUB share one carry path.
   always_comb begin
      w_sum   = 9'd0;
      w_alu   = 8'd0;
      w_alu_c = 1'b0;
      case (w_op)
         4'h1: begin
            w_sum   = {1'b0, w_a} + {1'b0, w_b};
            w_alu   = w_sum[7:0];
            w_alu_c = w_sum[8];
         end
         4'h2: begin
            w_sum   = {1'b0, w_a} - {1'b0, w_b};
            w_alu   = w_sum[7:0];
            w_alu_c = w_sum[8];
         end
         4'h3:    w_alu = w_a & w_b;
         4'h4:    w_alu = w_a | w_b;
         4'h5:    w_alu = w_a ^ w_b;
         4'h6:    w_alu = w_a << w_b[2:0];
         4'h7:    w_alu = w_a >> w_b[2:0];
         default: w_alu = 8'd0;
      endcase
   end

   assign w_pc_inc = r_pc + PCW'(1);

`ifdef CPU_BRANCH_EN
   logic       w_br_take;
   logic [7:0] w_d;
   assign w_d       = r_regs[w_rd];
   assign w_br_take = (w_op == 4'hC) || ((w_op == 4'hB) && (w_d == 8'd0));
   assign w_pc_next = w_br_take ? PCW'(w_imm) : r_pc;
`else
   assign w_pc_next = r_pc;
`endif

   assign w_daddr = ADDR_W'(w_a);

   // Single write port: ALU/LDI results in EXEC, load data when the MEM read completes.
   assign w_rf_we = ((r_state == S_EXEC) && (w_alu_op || (w_op == 4'h8))) ||
                    ((r_state == S_MEM) && mem_ready && !r_mem_we);
   assign w_rf_wdata = (r_state == S_MEM) ? (r_mem_addr[0] ? mem_rdata[15:8] : mem_rdata[7:0]) :
                       ((w_op == 4'h8) ? w_imm : w_alu);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) r_regs[i] <= 8'd0;
      end else if (w_rf_we) begin
         r_regs[w_rd] <= w_rf_wdata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_FETCH;
         r_pc        <= '0;
         r_inst      <= 16'd0;
         r_carry     <= 1'b0;
         r_zero      <= 1'b0;
         r_halted    <= 1'b0;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_be    <= 2'b00;
         r_mem_wdata <= 16'd0;
      end else begin
         case (r_state)
            S_FETCH: begin
               // Only the first fetch after reset starts here; later fetches are issued on entry.
               if (!r_mem_req) begin
                  r_mem_req  <= 1'b1;
                  r_mem_we   <= 1'b0;
                  r_mem_addr <= {r_pc, 1'b0};
                  r_mem_be   <= 2'b11;
               end else if (mem_ready) begin
                  r_mem_req <= 1'b0;
                  r_inst    <= mem_rdata;
                  r_pc      <= w_pc_inc;
                  r_state   <= S_EXEC;
               end
            end
            S_EXEC: begin
               if (w_alu_op) begin
                  r_carry <= w_alu_c;
                  r_zero  <= (w_alu == 8'd0);
               end
               if (w_is_mem) begin
                  r_mem_req   <= 1'b1;
                  r_mem_we    <= (w_op == 4'hA);
                  r_mem_addr  <= w_daddr;
                  r_mem_be    <= w_daddr[0] ? 2'b10 : 2'b01;
                  r_mem_wdata <= {w_b, w_b};
                  r_state     <= S_MEM;
               end else if (w_op == 4'hF) begin
                  r_halted <= 1'b1;
                  r_state  <= S_HALT;
               end else begin
                  r_pc       <= w_pc_next;
                  r_mem_req  <= 1'b1;
                  r_mem_we   <= 1'b0;
                  r_mem_addr <= {w_pc_next, 1'b0};
                  r_mem_be   <= 2'b11;
                  r_state    <= S_FETCH;
               end
            end
            S_MEM: begin
               if (mem_ready) begin
                  r_mem_req  <= 1'b1;
                  r_mem_we   <= 1'b0;
                  r_mem_addr <= {r_pc, 1'b0};
                  r_mem_be   <= 2'b11;
                  r_state    <= S_FETCH;
               end
            end
            default: begin
               r_mem_req <= 1'b0;
            end
         endcase
      end
   end

   assign mem_req   = r_mem_req;
   assign mem_we    = r_mem_we;
   assign mem_addr  = r_mem_addr;
   assign mem_be    = r_mem_be;
   assign mem_wdata = r_mem_wdata;
   assign flags     = {r_carry, r_zero};
   assign halted    = r_halted;

endmodule

// File: tb/tb_multicycle_cpu.sv
// tb_multicycle_cpu: directed checks of the multicycle core against a behavioural memory
// whose data accesses can be stalled by a programmable number of wait cycles.
module tb_multicycle_cpu;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        mem_req;
   logic        mem_we;
   logic [7:0]  mem_addr;
   logic [1:0]  mem_be;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata;
   logic        mem_ready;
   logic [1:0]  flags;
   logic        halted;

   multicycle_cpu #(.ADDR_W(8), .NREGS(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_be    (mem_be),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ready (mem_ready),
      .flags     (flags),
      .halted    (halted)
   );

   always #5 clk = ~clk;

   logic [15:0] mem [128];
   int          data_wait = 0;
   int          wait_cnt;
   int          cycle = 0;
   int          fetch_addr[$];
   int          fetch_cyc[$];
   int          st_n;
   logic [7:0]  st_addr;
   logic [1:0]  st_be;
   logic [15:0] st_wdata;
   int          unstable;
   logic        prev_stall;
   logic [26:0] prev_bus;
   logic        is_fetch;
   int          n_tests = 0;
   int          n_fail  = 0;

   // Fetches (both byte lanes, read) are never stalled; data accesses wait data_wait cycles.
   assign is_fetch  = (mem_be == 2'b11) && !mem_we;
   assign mem_ready = mem_req && (wait_cnt >= (is_fetch ? 0 : data_wait));
   assign mem_rdata = mem[mem_addr[7:1]];

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         wait_cnt   <= 0;
         st_n       <= 0;
         unstable   <= 0;
         prev_stall <= 1'b0;
      end else begin
         cycle    <= cycle + 1;
         wait_cnt <= (mem_req && !mem_ready) ? wait_cnt + 1 : 0;
         if (mem_req && mem_ready && is_fetch) begin
            fetch_addr.push_back(int'(mem_addr));
            fetch_cyc.push_back(cycle);
         end
         if (mem_req && mem_ready && mem_we) begin
            if (mem_be[0]) mem[mem_addr[7:1]][7:0]  <= mem_wdata[7:0];
            if (mem_be[1]) mem[mem_addr[7:1]][15:8] <= mem_wdata[15:8];
            st_n     <= st_n + 1;
            st_addr  <= mem_addr;
            st_be    <= mem_be;
            st_wdata <= mem_wdata;
         end
         if (prev_stall && mem_req && ({mem_addr, mem_we, mem_be, mem_wdata} != prev_bus))
            unstable <= unstable + 1;
         prev_stall <= mem_req && !mem_ready;
         prev_bus   <= {mem_addr, mem_we, mem_be, mem_wdata};
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic hold_reset();
      rst = 1'b1;
      @(negedge clk);
      fetch_addr.delete();
      fetch_cyc.delete();
      for (int i = 0; i < 128; i++) mem[i] = 16'h0000;
   endtask

   task automatic wait_fetches(input int n, input string tag);
      int k = 0;
      while (fetch_addr.size() < n && k < 300) begin
         @(negedge clk);
         k++;
      end
      check(tag, 32'(fetch_addr.size() >= n), 32'd1);
   endtask

   task automatic wait_halt(input string tag);
      int k = 0;
      while (!halted && k < 100) begin
         @(negedge clk);
         k++;
      end
      check(tag, 32'(halted), 32'd1);
   endtask

   // ST [r1],r2 then LD r5,[r1] at odd byte 0x11, with w wait cycles on each data access.
   task automatic mem_test(input int w, input string sfx);
      hold_reset();
      data_wait = w;
      mem[0] = 16'h8111;
      mem[1] = 16'h82AB;
      mem[2] = 16'hA012;
      mem[3] = 16'h9510;
      mem[4] = 16'hF000;
      mem[8] = 16'h5A5A;
      rst = 1'b0;
      wait_fetches(5, {"mem_fetches", sfx});
      check({"st_count", sfx}, 32'(st_n), 32'd1);
      check({"st_addr", sfx}, 32'(st_addr), 32'h11);
      check({"st_be", sfx}, 32'(st_be), 32'h2);
      check({"st_wdata", sfx}, 32'(st_wdata), 32'hABAB);
      check({"mem_word8", sfx}, 32'(mem[8]), 32'hAB5A);
      check({"ld_r5", sfx}, 32'(dut.r_regs[5]), 32'hAB);
      check({"st_latency", sfx}, 32'(fetch_cyc[3] - fetch_cyc[2]), 32'(3 + w));
      check({"ld_latency", sfx}, 32'(fetch_cyc[4] - fetch_cyc[3]), 32'(3 + w));
      check({"bus_stable", sfx}, 32'(unstable), 32'd0);
      wait_halt({"mem_halt", sfx});
   endtask

   initial begin
      int k;
      int req_cnt;

      // Reset state and the basic LDI/LDI/ADD program.
      hold_reset();
      mem[0] = 16'h8105;
      mem[1] = 16'h8203;
      mem[2] = 16'h1312;
      mem[3] = 16'hF000;
      check("reset_outputs", {5'd0, mem_req, mem_we, mem_addr, mem_be, mem_wdata, flags, halted}, 32'd0);
      check("reset_r3", 32'(dut.r_regs[3]), 32'd0);
      rst = 1'b0;
      #1;
      check("req_low_after_release", 32'(mem_req), 32'd0);
      @(negedge clk);
      check("first_req", {mem_req, mem_we, mem_be, mem_addr}, {1'b1, 1'b0, 2'b11, 8'h00});
      wait_fetches(4, "p1_fetches");
      check("p1_fetch0", 32'(fetch_addr[0]), 32'h0);
      check("p1_fetch1", 32'(fetch_addr[1]), 32'h2);
      check("p1_fetch2", 32'(fetch_addr[2]), 32'h4);
      check("p1_cycles", 32'(fetch_cyc[3] - fetch_cyc[0]), 32'd6);
      check("p1_r3", 32'(dut.r_regs[3]), 32'd8);
      check("p1_flags", 32'(flags), 32'b00);
      wait_halt("p1_halt");

      // HLT holds the bus idle until reset, which restarts fetch at 0.
      req_cnt = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (mem_req) req_cnt++;
      end
      check("halt_no_req", 32'(req_cnt), 32'd0);
      check("halt_stays", 32'(halted), 32'd1);
      rst = 1'b1;
      #1;
      check("halt_cleared", 32'(halted), 32'd0);
      @(negedge clk);
      fetch_addr.delete();
      fetch_cyc.delete();
      rst = 1'b0;
      wait_fetches(1, "restart_fetch");
      check("restart_addr", 32'(fetch_addr[0]), 32'h0);

      // Carry and zero from ADD overflow, borrow from SUB.
      hold_reset();
      mem[0] = 16'h81FF;
      mem[1] = 16'h8201;
      mem[2] = 16'h1312;
      mem[3] = 16'h2421;
      mem[4] = 16'hF000;
      rst = 1'b0;
      wait_fetches(4, "p2_fetches");
      check("add_wrap_r3", 32'(dut.r_regs[3]), 32'h00);
      check("add_flags", 32'(flags), 32'b11);
      wait_fetches(5, "p2_fetches_sub");
      check("sub_r4", 32'(dut.r_regs[4]), 32'h02);
      check("sub_flags", 32'(flags), 32'b10);

      mem_test(0, "_w0");
      mem_test(3, "_w3");
      data_wait = 0;

      // Branches: BEQZ not taken (r0=1), BEQZ taken (r1=0), then JMP.
      hold_reset();
      mem[0]    = 16'h8001;
      mem[1]    = 16'hB020;
      mem[2]    = 16'hB120;
      mem[3]    = 16'hF000;
      mem[8'h20] = 16'hC030;
      mem[8'h30] = 16'hF000;
      rst = 1'b0;
`ifdef CPU_BRANCH_EN
      wait_fetches(5, "br_fetches");
      check("beqz_nottaken", 32'(fetch_addr[2]), 32'h04);
      check("beqz_taken", 32'(fetch_addr[3]), 32'h40);
      check("jmp_target", 32'(fetch_addr[4]), 32'h60);
`else
      wait_fetches(4, "br_fetches");
      check("beqz_nottaken", 32'(fetch_addr[2]), 32'h04);
      check("beqz_as_nop", 32'(fetch_addr[3]), 32'h06);
`endif
      check("branch_cycles", 32'(fetch_cyc[3] - fetch_cyc[2]), 32'd2);
      wait_halt("br_halt");

      // Reset during a stalled store abandons it.
      hold_reset();
      data_wait = 1000;
      mem[0] = 16'h8111;
      mem[1] = 16'h82AB;
      mem[2] = 16'hA012;
      mem[3] = 16'hF000;
      mem[8] = 16'h5A5A;
      rst = 1'b0;
      k = 0;
      while (!(mem_req && mem_we) && k < 100) begin
         @(negedge clk);
         k++;
      end
      check("store_pending", {mem_req, mem_we}, 2'b11);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("rst_drops_req", 32'(mem_req), 32'd0);
      check("rst_r1", 32'(dut.r_regs[1]), 32'd0);
      check("rst_r2", 32'(dut.r_regs[2]), 32'd0);
      @(negedge clk);
      check("store_abandoned", 32'(mem[8]), 32'h5A5A);
      data_wait = 0;
      fetch_addr.delete();
      fetch_cyc.delete();
      rst = 1'b0;
      wait_fetches(1, "post_rst_fetch");
      check("post_rst_addr", 32'(fetch_addr[0]), 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
